// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch front end: the sequencer state
// encoding and the common request-issue rule.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  // IDLE    : no memory request outstanding
  // BUSY    : request outstanding, its data will be buffered
  // DISCARD : request outstanding, its data belongs to a flushed path
  typedef enum logic [1:0] {
    FU_IDLE    = 2'd0,
    FU_BUSY    = 2'd1,
    FU_DISCARD = 2'd2
  } fu_state_t;

  // A new read may be issued only when fetching is enabled, no redirect is
  // being taken this cycle and the buffer has a free slot.
  function automatic logic issue_ok(input logic fetch_en,
                                    input logic redirect,
                                    input logic room);
    return fetch_en && !redirect && room;
  endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch unit's control, memory and instruction-delivery signals.
//   master : the fetch unit (drives mem_req/mem_addr and the instruction side)
//   slave  : the environment (control unit + instruction memory)
// Signals:
//   fetch_en, redirect, redirect_addr    control inputs to the fetch unit
//   mem_req, mem_addr                    read request towards memory
//   mem_ack, mem_rdata                   read completion from memory
//   inst_valid, inst_ready               instruction handshake
//   opcode, src, dst, inst_pc            head instruction fields and address
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4,
  parameter int REG_W  = 2
);

  logic              fetch_en;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              inst_valid;
  logic              inst_ready;
  logic [OPC_W-1:0]  opcode;
  logic [REG_W-1:0]  src;
  logic [REG_W-1:0]  dst;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    input  fetch_en, redirect, redirect_addr,
    input  mem_ack, mem_rdata,
    input  inst_ready,
    output mem_req, mem_addr,
    output inst_valid, opcode, src, dst, inst_pc
  );

  modport slave (
    output fetch_en, redirect, redirect_addr,
    output mem_ack, mem_rdata,
    output inst_ready,
    input  mem_req, mem_addr,
    input  inst_valid, opcode, src, dst, inst_pc
  );

endinterface : fetch_unit_if

// File: rtl/fetch_unit_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Synchronous FIFO holding fetched {instruction, address} pairs. The head entry
// is presented combinationally on rdata, so an entry pushed on one edge is
// visible right after that edge.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write an entry (ignored when full unless popping)
//   pop          remove the head entry (ignored when empty)
//   flush        discard all entries; overrides push and pop
//   rdata        head entry (don't-care when count == 0)
//   count        current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  // A pop frees the full slot in the same cycle, so push+pop while full is
  // accepted; pointers wrap naturally because DEPTH is a power of two.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL_CNT) || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count and the pointers alone
  // define which entries are valid, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule : fetch_buffer

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: program counter, memory request/acknowledge
// sequencer tolerating wait states, and a DEPTH-entry instruction buffer that
// delivers decoded opcode/src/dst fields plus the fetch address.
// Ports:
//   clk     clock, all state on rising edge
//   reset   asynchronous active-low reset
//   bus     fetch_unit_if.master: fetch_en, redirect, redirect_addr,
//           mem_req/mem_addr/mem_ack/mem_rdata, inst_valid/inst_ready,
//           opcode, src, dst, inst_pc
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                OPC_W    = 4,
  parameter int                REG_W    = 2,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fu_state_t                state;
  logic [ADDR_W-1:0]        pc;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_next;
  logic                     push;
  logic                     pop;
  logic                     valid;
  logic                     room_now;
  logic                     room_next;
  logic [DATA_W+ADDR_W-1:0] head;
  logic [DATA_W-1:0]        head_inst;

  // Only a BUSY completion is kept; a redirect in the same cycle drops it.
  assign push  = (state == FU_BUSY) && bus.mem_ack && !bus.redirect;
  // A pop coinciding with a redirect is void: the flush wins.
  assign valid = (count != '0);
  assign pop   = valid && bus.inst_ready && !bus.redirect;

  always_comb begin
    // NOTE: default assignment first so every path drives count_next and no
    // latch is inferred.
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  // IDLE/DISCARD issue on current occupancy; BUSY chains on the occupancy
  // after this cycle's push/pop so a back-to-back request never overflows.
  assign room_now  = (count < FULL_CNT);
  assign room_next = (count_next < FULL_CNT);

  fetch_buffer #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata ({bus.mem_rdata, bus.mem_addr}),
    .pop   (pop),
    .flush (bus.redirect),
    .rdata (head),
    .count (count)
  );

  assign head_inst      = head[ADDR_W +: DATA_W];
  assign bus.inst_valid = valid;
  assign bus.inst_pc    = head[ADDR_W-1:0];
  assign bus.opcode     = head_inst[DATA_W-1 -: OPC_W];
  assign bus.src        = head_inst[DATA_W-OPC_W-1 -: REG_W];
  assign bus.dst        = head_inst[REG_W-1:0];

  // Sequencer: requests are never withdrawn, so mem_req only falls on the
  // edge that samples mem_ack (or on reset).
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FU_IDLE;
      pc           <= RESET_PC;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= RESET_PC;
    end else begin
      case (state)
        FU_IDLE: begin
          if (bus.redirect) pc <= bus.redirect_addr;
          if (issue_ok(bus.fetch_en, bus.redirect, room_now)) begin
            state        <= FU_BUSY;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= pc;
          end
        end

        FU_BUSY: begin
          if (bus.redirect) begin
            pc <= bus.redirect_addr;
            if (bus.mem_ack) begin
              state       <= FU_IDLE;
              bus.mem_req <= 1'b0;
            end else begin
              state <= FU_DISCARD;
            end
          end else if (bus.mem_ack) begin
            pc <= pc + ADDR_W'(1);
            if (issue_ok(bus.fetch_en, 1'b0, room_next)) begin
              bus.mem_addr <= pc + ADDR_W'(1);
            end else begin
              state       <= FU_IDLE;
              bus.mem_req <= 1'b0;
            end
          end
        end

        FU_DISCARD: begin
          if (bus.redirect) begin
            pc <= bus.redirect_addr;
            // The stale request finishing now must not leave us waiting for
            // an acknowledge that will never come.
            if (bus.mem_ack) begin
              state       <= FU_IDLE;
              bus.mem_req <= 1'b0;
            end
          end else if (bus.mem_ack) begin
            if (issue_ok(bus.fetch_en, 1'b0, room_now)) begin
              state        <= FU_BUSY;
              bus.mem_addr <= pc;
            end else begin
              state       <= FU_IDLE;
              bus.mem_req <= 1'b0;
            end
          end
        end

        default: begin
          state       <= FU_IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule : fetch_unit
